// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register busy/latency scoreboard driving ID hold, bypass and redirect.
// Define HAZARD_STATS_EN to add stall/redirect statistics counters and stats_clr.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int MAX_LAT  = 7,
    parameter int BR_EXTRA = 1,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_ID,
    input  logic [REG_AW-1:0] rt_ID,
    input  logic              use_rs_ID,
    input  logic              use_rt_ID,
    input  logic              branch_ID,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic [2:0]        issue_lat,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              branch_taken,
    input  logic [1:0]        jump,
`ifdef HAZARD_STATS_EN
    input  logic              stats_clr,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       branch_stall_cycles,
    output logic [31:0]       redirect_count,
`endif
    output logic              hold,
    output logic              redirect,
    output logic              bypass_rs,
    output logic              bypass_rt
);

    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_cnt [NUM_REGS];

    logic             w_need_rs;
    logic             w_need_rt;
    logic             w_wb_rs;
    logic             w_wb_rt;
    logic             w_rdy_rs;
    logic             w_rdy_rt;
    logic             w_hold;
    logic             w_redirect;
    logic             w_fire;
    logic [CNT_W-1:0] w_arm;

    function automatic logic f_ready(input logic busy, input logic [CNT_W-1:0] cnt,
                                     input logic br);
        if (!busy)
            return 1'b1;
        if (br)
            return cnt == '0;
        return cnt <= CNT_W'(BR_EXTRA);
    endfunction

    assign w_need_rs = use_rs_ID && (rs_ID != '0);
    assign w_need_rt = use_rt_ID && (rt_ID != '0);

    // A same-cycle RF write to a source behaves as write-through.
    assign w_wb_rs = w_need_rs && wb_valid && (wb_dest == rs_ID);
    assign w_wb_rt = w_need_rt && wb_valid && (wb_dest == rt_ID);

    assign w_rdy_rs = w_wb_rs || f_ready(r_busy[rs_ID], r_cnt[rs_ID], branch_ID);
    assign w_rdy_rt = w_wb_rt || f_ready(r_busy[rt_ID], r_cnt[rt_ID], branch_ID);

    assign w_hold     = (w_need_rs && !w_rdy_rs) || (w_need_rt && !w_rdy_rt);
    assign w_redirect = (branch_ID && branch_taken && !w_hold) || (jump != 2'b00);

    assign hold      = w_hold;
    assign redirect  = w_redirect;
    assign bypass_rs = w_need_rs && !w_hold && (w_wb_rs || r_busy[rs_ID]);
    assign bypass_rt = w_need_rt && !w_hold && (w_wb_rt || r_busy[rt_ID]);

    assign w_fire = issue_valid && !w_hold && issue_we && (issue_dest != '0);

    // Loaded value is what the dependant in ID sees on the first cycle after issue.
    assign w_arm = CNT_W'(issue_lat) + CNT_W'(BR_EXTRA - 1);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst || i == 0) begin
                r_busy[i] <= 1'b0;
                r_cnt[i]  <= '0;
            end else if (w_fire && issue_dest == REG_AW'(i)) begin
                r_busy[i] <= 1'b1;
                r_cnt[i]  <= w_arm;
            end else if (wb_valid && wb_dest == REG_AW'(i)) begin
                r_busy[i] <= 1'b0;
                r_cnt[i]  <= '0;
            end else if (r_cnt[i] != '0) begin
                r_cnt[i]  <= r_cnt[i] - 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall;
    logic [31:0] r_br_stall;
    logic [31:0] r_redir;

    always_ff @(posedge clk) begin
        if (!rst || stats_clr) begin
            r_stall    <= '0;
            r_br_stall <= '0;
            r_redir    <= '0;
        end else begin
            if (w_hold)
                r_stall <= r_stall + 32'd1;
            if (w_hold && branch_ID)
                r_br_stall <= r_br_stall + 32'd1;
            if (w_redirect)
                r_redir <= r_redir + 32'd1;
        end
    end

    assign stall_cycles        = r_stall;
    assign branch_stall_cycles = r_br_stall;
    assign redirect_count      = r_redir;
`endif

    a_lat_legal: assert property (@(posedge clk) disable iff (!rst)
        (issue_valid && issue_we && !w_hold) |->
            (issue_lat != 3'd0 && 32'(issue_lat) <= MAX_LAT));

endmodule
